// File: rtl/dm_wait_responder_pkg.sv
// Shared types and constants for the wait-state data-memory responder.
package dm_wait_responder_pkg;

    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        DM_IDLE = 2'd0,
        DM_WAIT = 2'd1,
        DM_RESP = 2'd2
    } dmState_t;

    function automatic logic isAligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/dm_wait_responder_if.sv
// CPU data-memory bus: the CPU is the master, the responder is the slave.
interface dm_wait_responder_if;

    logic        memRead;
    logic        memWrite;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        stall;
    logic        ready;
    logic        error;

    modport master (
        output memRead, memWrite, address, writeData,
        input  readData, stall, ready, error
    );

    modport slave (
        input  memRead, memWrite, address, writeData,
        output readData, stall, ready, error
    );

endinterface

// File: rtl/dm_wait_responder_array.sv
// Word-addressed storage: synchronous write, asynchronous read, contents survive reset.
module dm_wait_responder_array #(
    parameter  int DEPTH_WORDS = 256,
    localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] wIdx,
    input  logic [31:0]      wData,
    input  logic [IDX_W-1:0] rIdx,
    output logic [31:0]      rData
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wIdx] <= wData;
        end
    end

    assign rData = mem[rIdx];

endmodule

// File: rtl/dm_wait_responder.sv
// Data-memory responder that stalls the CPU for a fixed number of wait states per access.
module dm_wait_responder
    import dm_wait_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    dm_wait_responder_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_CYCLES);

    dmState_t              state;
    logic [WAIT_CNT_W-1:0] waitCnt;
    logic [IDX_W-1:0]      capIdx;
    logic [31:0]           capData;
    logic                  capWrite;
    logic [31:0]           readDataQ;
    logic                  errorQ;

    logic             reqAny;
    logic             reqBad;
    logic             reqOk;
    logic [IDX_W-1:0] reqIdx;
    logic [IDX_W-1:0] rIdx;
    logic [31:0]      rData;
    logic             we;
    logic             unusedAddr;

    assign reqAny = bus.memRead | bus.memWrite;
    assign reqBad = reqAny && ((bus.memRead && bus.memWrite) || !isAligned(bus.address));
    assign reqOk  = reqAny && !reqBad;
    // Upper address bits are dropped so accesses wrap modulo DEPTH_WORDS.
    assign reqIdx     = bus.address[IDX_W+1:2];
    assign unusedAddr = ^bus.address[31:IDX_W+2];

    // In IDLE the read port looks at the live address so a zero-wait read can load on the accept edge.
    assign rIdx = (state == DM_IDLE) ? reqIdx : capIdx;
    assign we   = (state == DM_RESP) && capWrite && !reset;

    dm_wait_responder_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) uArray (
        .clk  (clk),
        .we   (we),
        .wIdx (capIdx),
        .wData(capData),
        .rIdx (rIdx),
        .rData(rData)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= DM_IDLE;
            waitCnt   <= '0;
            capWrite  <= 1'b0;
            readDataQ <= '0;
            errorQ    <= 1'b0;
        end else begin
            errorQ <= 1'b0;
            case (state)
                DM_IDLE: begin
                    if (reqBad) begin
                        errorQ <= 1'b1;
                    end else if (reqOk) begin
                        capIdx   <= reqIdx;
                        capData  <= bus.writeData;
                        capWrite <= bus.memWrite;
                        if (WAIT_CYCLES == 0) begin
                            state <= DM_RESP;
                            if (bus.memRead) begin
                                readDataQ <= rData;
                            end
                        end else begin
                            state   <= DM_WAIT;
                            waitCnt <= WAIT_INIT;
                        end
                    end
                end
                DM_WAIT: begin
                    waitCnt <= waitCnt - 1'b1;
                    if (waitCnt <= 1) begin
                        state <= DM_RESP;
                        if (!capWrite) begin
                            readDataQ <= rData;
                        end
                    end
                end
                DM_RESP: state <= DM_IDLE;
                default: state <= DM_IDLE;
            endcase
        end
    end

    // stall is combinational in IDLE so the CPU freezes in the same cycle it issues the request.
    assign bus.stall    = (state == DM_WAIT) || ((state == DM_IDLE) && reqOk);
    assign bus.ready    = (state == DM_RESP);
    assign bus.error    = errorQ;
    assign bus.readData = readDataQ;

endmodule
